// File: rtl/sip_tap_controller.sv
// Primary 1149.1-style TAP: 16-state FSM, 4-bit IR, IDCODE/BYPASS/CONFIG data registers.
// Define SIP_TAP_STAP_ACCESS_EN to route the secondary TAP's STDO to TDO under opcode 0011.
module sip_tap_controller #(
  parameter logic [31:0] IDCODE_VAL = 32'h1234_5679,
  parameter int unsigned CFG_WIDTH  = 8
) (
  input  logic                 TCK,
  input  logic                 TRST_N,
  input  logic                 TMS,
  input  logic                 TDI,
  input  logic                 STDO,
  output logic                 TDO,
  output logic [CFG_WIDTH-1:0] config_reg,
  output logic [3:0]           ir_out,
  output logic [3:0]           tap_state
);

  typedef enum logic [3:0] {
    TLR    = 4'hF, RTI    = 4'hC,
    SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR  = 4'h2, EX1_DR = 4'h1,
    PAU_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
    SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA, EX1_IR = 4'h9,
    PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
  } tap_state_t;

  localparam logic [3:0] IR_IDCODE = 4'b0001;
  localparam logic [3:0] IR_CONFIG = 4'b0010;
  localparam logic [3:0] IR_STAP   = 4'b0011;
  localparam logic [3:0] IR_CAPT   = 4'b0101;

  tap_state_t           r_state;
  tap_state_t           w_next;
  logic [3:0]           r_ir_shift;
  logic [3:0]           r_ir;
  logic [31:0]          r_dr_id;
  logic [CFG_WIDTH-1:0] r_dr_cfg;
  logic [CFG_WIDTH-1:0] r_cfg;
  logic [CFG_WIDTH-1:0] w_cfg_shifted;
  logic                 r_bypass;
  logic                 w_sel_id;
  logic                 w_sel_cfg;
  logic                 w_sel_stap;

  assign w_sel_id  = (r_ir == IR_IDCODE);
  assign w_sel_cfg = (r_ir == IR_CONFIG);
`ifdef SIP_TAP_STAP_ACCESS_EN
  assign w_sel_stap = (r_ir == IR_STAP);
`else
  assign w_sel_stap = 1'b0;
`endif

  // A 1-bit CONFIG register has no upper slice to shift down.
  generate
    if (CFG_WIDTH == 1) begin : g_cfg_shift_1
      assign w_cfg_shifted = TDI;
    end else begin : g_cfg_shift_n
      assign w_cfg_shifted = {TDI, r_dr_cfg[CFG_WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    w_next = r_state;
    case (r_state)
      TLR:    w_next = TMS ? TLR    : RTI;
      RTI:    w_next = TMS ? SEL_DR : RTI;
      SEL_DR: w_next = TMS ? SEL_IR : CAP_DR;
      CAP_DR: w_next = TMS ? EX1_DR : SH_DR;
      SH_DR:  w_next = TMS ? EX1_DR : SH_DR;
      EX1_DR: w_next = TMS ? UPD_DR : PAU_DR;
      PAU_DR: w_next = TMS ? EX2_DR : PAU_DR;
      EX2_DR: w_next = TMS ? UPD_DR : SH_DR;
      UPD_DR: w_next = TMS ? SEL_DR : RTI;
      SEL_IR: w_next = TMS ? TLR    : CAP_IR;
      CAP_IR: w_next = TMS ? EX1_IR : SH_IR;
      SH_IR:  w_next = TMS ? EX1_IR : SH_IR;
      EX1_IR: w_next = TMS ? UPD_IR : PAU_IR;
      PAU_IR: w_next = TMS ? EX2_IR : PAU_IR;
      EX2_IR: w_next = TMS ? UPD_IR : SH_IR;
      UPD_IR: w_next = TMS ? SEL_DR : RTI;
      default: w_next = TLR;
    endcase
  end

  always_ff @(posedge TCK) begin
    if (!TRST_N) begin
      r_state    <= TLR;
      r_ir_shift <= '0;
      r_ir       <= IR_IDCODE;
      r_dr_id    <= '0;
      r_dr_cfg   <= '0;
      r_cfg      <= '0;
      r_bypass   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        CAP_IR: r_ir_shift <= IR_CAPT;
        SH_IR:  r_ir_shift <= {TDI, r_ir_shift[3:1]};
        UPD_IR: r_ir       <= r_ir_shift;
        CAP_DR: begin
          if (w_sel_id)       r_dr_id  <= IDCODE_VAL;
          else if (w_sel_cfg) r_dr_cfg <= r_cfg;
          else                r_bypass <= 1'b0;
        end
        SH_DR: begin
          if (w_sel_id)       r_dr_id  <= {TDI, r_dr_id[31:1]};
          else if (w_sel_cfg) r_dr_cfg <= w_cfg_shifted;
          else                r_bypass <= TDI;
        end
        UPD_DR: if (w_sel_cfg) r_cfg <= r_dr_cfg;
        default: ;
      endcase
      // Arriving in TLR by TMS restores the reset instruction and disables the secondary TAP.
      if (w_next == TLR) begin
        r_ir  <= IR_IDCODE;
        r_cfg <= '0;
      end
    end
  end

  always_comb begin
    TDO = 1'b0;
    if (r_state == SH_IR) begin
      TDO = r_ir_shift[0];
    end else if (r_state == SH_DR) begin
      if (w_sel_id)                  TDO = r_dr_id[0];
      else if (w_sel_cfg)            TDO = r_dr_cfg[0];
      else if (w_sel_stap && r_cfg[0]) TDO = STDO;
      else                           TDO = r_bypass;
    end
  end

  assign tap_state  = r_state;
  assign ir_out     = r_ir;
  assign config_reg = r_cfg;

endmodule

// File: tb/tb_sip_tap_controller.sv
// Scoreboard bench for sip_tap_controller: transaction-level model of IR/DR scans
// predicts every TDO bit; a negedge monitor pops and compares whenever the TAP is shifting.
module tb_sip_tap_controller;
  localparam logic [31:0] IDV = 32'h1234_5679;
  localparam int CW = 8;
`ifdef SIP_TAP_STAP_ACCESS_EN
  localparam bit STAP_EN = 1'b1;
`else
  localparam bit STAP_EN = 1'b0;
`endif

  logic          TCK = 1'b0;
  logic          TRST_N = 1'b0;
  logic          TMS = 1'b1;
  logic          TDI = 1'b0;
  logic          STDO = 1'b0;
  logic          TDO;
  logic [CW-1:0] config_reg;
  logic [3:0]    ir_out;
  logic [3:0]    tap_state;

  sip_tap_controller #(.IDCODE_VAL(IDV), .CFG_WIDTH(CW)) dut (
    .TCK(TCK), .TRST_N(TRST_N), .TMS(TMS), .TDI(TDI), .STDO(STDO),
    .TDO(TDO), .config_reg(config_reg), .ir_out(ir_out), .tap_state(tap_state)
  );

  always #5 TCK = ~TCK;

  int n_tests = 0;
  int n_fail  = 0;
  bit exp_q[$];
  bit path[$];
  bit stap_live;
  logic [3:0]    m_ir;
  logic [CW-1:0] m_cfg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a shift state means the DUT is presenting a scan bit.
  always @(negedge TCK) begin
    if (TRST_N) begin
      if (tap_state == 4'h2 || tap_state == 4'hA) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_empty: TDO=%0b in state %0h with no expected bit", TDO, tap_state);
        end else begin
          chk("tdo_shift", TDO, exp_q.pop_front());
        end
      end else begin
        chk("tdo_idle", TDO, 0);
      end
    end
  end

  task automatic step(input bit tms, input bit tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    #1;
  endtask

  task automatic do_reset();
    TRST_N = 1'b0;
    TMS = 1'($urandom_range(0, 1));
    @(posedge TCK);
    #1;
    TRST_N = 1'b1;
    m_ir = 4'b0001;
    m_cfg = '0;
    exp_q.delete();
    chk("rst_state", tap_state, 4'hF);
    chk("rst_ir", ir_out, 4'b0001);
    chk("rst_cfg", config_reg, 0);
    chk("rst_tdo", TDO, 0);
  endtask

  task automatic go_tlr();
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom_range(0, 1)));
    m_ir = 4'b0001;
    m_cfg = '0;
    chk("tlr_state", tap_state, 4'hF);
    chk("tlr_ir", ir_out, 4'b0001);
    chk("tlr_cfg", config_reg, 0);
  endtask

  task automatic shift_one(input bit t, input bit tms, input bit is_dr);
    bit s;
    s = 1'($urandom_range(0, 1));
    STDO = s;
    if (is_dr && stap_live) begin
      exp_q.push_back(s);
    end else begin
      exp_q.push_back(path.pop_front());
      path.push_back(t);
    end
    step(tms, t);
  endtask

  // Shift n bits LSB first, optionally detouring through Pause; ends in Exit1.
  task automatic shift_bits(input logic [63:0] data, input int n, input bit is_dr);
    for (int i = 0; i < n; i++) begin
      bit last;
      bit pz;
      int k;
      last = (i == n - 1);
      pz = !last && ($urandom_range(0, 7) == 0);
      shift_one(data[i], last || pz, is_dr);
      if (pz) begin
        k = $urandom_range(0, 3);
        step(1'b0, 1'b0);
        chk("pause_state", tap_state, is_dr ? 4'h3 : 4'hB);
        for (int j = 0; j < k; j++) step(1'b0, 1'($urandom_range(0, 1)));
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
      end
    end
  endtask

  task automatic check_idle(input string name);
    chk({name, "_state"}, tap_state, 4'hC);
    chk({name, "_ir"}, ir_out, m_ir);
    chk({name, "_cfg"}, config_reg, m_cfg);
  endtask

  // From RTI: load an instruction and return to RTI.
  task automatic scan_ir(input logic [3:0] code);
    logic [3:0] cap;
    cap = 4'b0101;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    path.delete();
    for (int i = 0; i < 4; i++) path.push_back(cap[i]);
    shift_bits({60'b0, code}, 4, 1'b0);
    step(1'b1, 1'b0);
    chk("updir_hold", ir_out, m_ir);
    for (int i = 0; i < 4; i++) m_ir[i] = path[i];
    step(1'b0, 1'b0);
    check_idle("ir_scan");
  endtask

  task automatic enter_shdr();
    logic [31:0] idv;
    idv = IDV;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    path.delete();
    stap_live = STAP_EN && (m_ir == 4'b0011) && m_cfg[0];
    if (m_ir == 4'b0001)      for (int i = 0; i < 32; i++) path.push_back(idv[i]);
    else if (m_ir == 4'b0010) for (int i = 0; i < CW; i++) path.push_back(m_cfg[i]);
    else                      path.push_back(1'b0);
  endtask

  // From RTI: capture, shift n bits, update, back to RTI.
  task automatic scan_dr(input logic [63:0] data, input int n);
    enter_shdr();
    shift_bits(data, n, 1'b1);
    step(1'b1, 1'b0);
    chk("upddr_state", tap_state, 4'h5);
    chk("upddr_hold", config_reg, m_cfg);
    if (m_ir == 4'b0010) for (int i = 0; i < CW; i++) m_cfg[i] = path[i];
    step(1'b0, 1'b0);
    check_idle("dr_scan");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] code;
    stap_live = 1'b0;
    m_ir = 4'b0001;
    m_cfg = '0;
    #1;
    do_reset();
    step(1'b0, 1'b0);
    scan_dr({$urandom, $urandom}, 32);

    scan_ir(4'b0010);
    scan_dr(64'hA5, 8);
    chk("cfg_a5", config_reg, 8'hA5);
    scan_dr(64'hA5, 8);

    go_tlr();
    step(1'b0, 1'b0);

    scan_ir(4'b1111);
    scan_dr(64'b1101, 4);

    scan_ir(4'b0010);
    scan_dr(64'h01, 8);
    scan_ir(4'b0011);
    scan_dr({$urandom, $urandom}, 12);
    scan_ir(4'b0010);
    scan_dr(64'h00, 8);
    scan_ir(4'b0011);
    scan_dr({$urandom, $urandom}, 6);

    scan_ir(4'b0010);
    scan_dr(64'hA5, 8);
    enter_shdr();
    for (int i = 0; i < 3; i++) shift_one(1'($urandom_range(0, 1)), 1'b0, 1'b1);
    do_reset();
    step(1'b0, 1'b0);

    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 9))
        0: begin go_tlr(); step(1'b0, 1'b0); end
        1: begin do_reset(); step(1'b0, 1'b0); end
        2, 3, 4: begin
          case ($urandom_range(0, 4))
            0: code = 4'b0001;
            1: code = 4'b0010;
            2: code = 4'b0011;
            3: code = 4'b1111;
            default: code = 4'($urandom_range(0, 15));
          endcase
          scan_ir(code);
        end
        default: scan_dr({$urandom, $urandom}, $urandom_range(1, 40));
      endcase
    end

    step(1'b0, 1'b0);
    chk("sb_leftover", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sip_tap_controller.md
# sip_tap_controller

Primary IEEE 1149.1-style TAP controller for the SiP and the upstream stage of the secondary-TAP gate. It runs the 16-state TAP FSM, holds a 4-bit instruction register, and implements IDCODE, BYPASS and an 8-bit CONFIG data register. The CONFIG register is driven out as `config_reg`, which enables and gates the secondary TAP. When the secondary TAP is selected, its `STDO` is routed back to the primary `TDO`.

## Interface
- `IDCODE_VAL`, default 32'h1234_5679: value captured by IDCODE. Bit 0 must be 1.
- `CFG_WIDTH`, default 8: CONFIG register width. Must be at least 1.
- `TCK`  in  1  TAP clock. All state changes on the rising edge.
- `TRST_N`  in  1  reset: one clock; reset is synchronous and active-low.
- `TMS`  in  1  mode select.
- `TDI`  in  1  serial data in.
- `STDO`  in  1  serial return from the secondary TAP.
- `TDO`  out  1  serial data out.
- `config_reg`  out  CFG_WIDTH  CONFIG register contents. Bit 0 enables the secondary TAP.
- `ir_out`  out  4  current instruction.
- `tap_state`  out  4  FSM state encoding, for debug.

## Operation
- State encodings: TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauIR=B, Ex2IR=8, UpdIR=D.
- Transitions, written as TMS=0 / TMS=1:
  - TLR: RTI/TLR. RTI: RTI/SelDR. SelDR: CapDR/SelIR. SelIR: CapIR/TLR.
  - CapxR: ShxR/Ex1xR. ShxR: ShxR/Ex1xR. Ex1xR: PauxR/UpdxR.
  - PauxR: PauxR/Ex2xR. Ex2xR: ShxR/UpdxR. UpdxR: RTI/SelDR.
- Instruction decode:
  - 0001 IDCODE: 32-bit path.
  - 0010 CONFIG: CFG_WIDTH-bit path.
  - 0011 STAP_ACCESS: external path through `STDO`.
  - 1111 and all other codes: BYPASS, 1-bit path.
- Shift rules:
  - Shift registers shift right. `TDI` enters the MSB; the LSB is shifted out.
- Capture rules:
  - CapIR loads 4'b0101 into the IR shift register.
  - CapDR loads `IDCODE_VAL` for IDCODE, `config_reg` for CONFIG, and 0 for BYPASS.
- Update rules:
  - UpdIR loads `ir_out` from the IR shift register.
  - UpdDR under CONFIG loads `config_reg` from the DR shift register.
  - No other instruction updates anything.
- `TDO` source (combinational):
  - ShIR: IR shift LSB.
  - ShDR: LSB of the selected DR path.
  - STAP_ACCESS in ShDR with `config_reg[0]`=1: `STDO`.
  - STAP_ACCESS in ShDR with `config_reg[0]`=0: bypass bit.
  - All other states: 0.
- Entering TLR by either route (`TRST_N` or TMS) sets `ir_out` to 0001 and `config_reg` to 0. This disables the secondary TAP.

## Timing
- `TRST_N` low at a rising edge gives, from the next cycle: `tap_state`=F, `ir_out`=0001, `config_reg`=0, `TDO`=0, and all shift registers cleared.
- `TRST_N` takes priority over TMS and over any in-progress shift or update. A partial shift is discarded.
- Five consecutive TMS=1 edges reach TLR from any state.
- Register actions occur on the rising edge taken while in the named state. Capture, each shift and update each take one edge.
- `TDO` equals shift LSB while in a Shift state. A bit presented on `TDI` appears at `TDO` after N shift edges, where N is the path length; BYPASS gives a 1-edge delay.
- `config_reg` changes exactly one edge after the UpdDR state under CONFIG, and only then (apart from reset and TLR).
- Pause and Exit states hold shift contents unchanged.

## Configuration
- `SIP_TAP_STAP_ACCESS_EN` defined: opcode 0011 selects STAP_ACCESS as described under Operation.
- Not defined: 0011 decodes as BYPASS and `STDO` is ignored. All other behaviour is identical.

## Test plan
- Reset: pulse `TRST_N`=0 for one edge mid-ShDR → `tap_state`=F, `ir_out`=0001, `config_reg`=0, `TDO`=0.
- IDCODE: after reset, TMS 0,1,0,0 then 32 shifts → `TDO` serialises 32'h1234_5679, LSB first.
- CONFIG write and readback:
  - Load IR 0010, shift in 8'hA5, pass UpdDR → `config_reg`=8'hA5.
  - Next CapDR/ShDR → `TDO` returns A5, LSB first.
- TLR via TMS: with `config_reg`=8'hA5, hold TMS=1 for 5 edges → `tap_state`=F, `config_reg`=0, `ir_out`=0001.
- BYPASS: IR 1111, shift 1,0,1,1 → `TDO` shows 1,0,1,1 delayed by one edge; CapIR shifts out 1,0,1,0.
- STAP_ACCESS (macro defined):
  - `config_reg[0]`=1, ShDR, toggle `STDO` → `TDO` follows `STDO`.
  - `config_reg[0]`=0 → `TDO` acts as bypass.
  - Macro undefined → `TDO` acts as bypass.
